// File: rtl/fdiv_fps_seq.sv
// Multi-cycle binary32 divider (F.DIV.S) with restoring significand division.
// Handshake: start_i accepted in IDLE or DONE, done_o pulses with the result.
module fdiv_fps_seq #(
    parameter logic [31:0] CANON_NAN = 32'h7fc00000,
    parameter int          QBITS     = 26
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic [2:0]  frm_i,
    output logic [31:0] c_o,
    output logic [4:0]  fflags_o,
    output logic        busy_o,
    output logic        done_o
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CHECK = 3'd1;
    localparam logic [2:0] S_NORM  = 3'd2;
    localparam logic [2:0] S_DIV   = 3'd3;
    localparam logic [2:0] S_ROUND = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic [2:0]        frm_q, frm_d;
    logic [24:0]       sig_a_q, sig_a_d;
    logic [23:0]       sig_b_q, sig_b_d;
    logic signed [9:0] exp_a_q, exp_a_d, exp_b_q, exp_b_d;
    logic [25:0]       quo_q, quo_d;
    logic [4:0]        cnt_q, cnt_d;
    logic              spec_q, spec_d;
    logic [31:0]       spec_res_q, spec_res_d;
    logic [4:0]        spec_flg_q, spec_flg_d;
    logic [31:0]       c_q, c_d;
    logic [4:0]        fflags_q, fflags_d;

    logic [7:0]  a_exp, b_exp;
    logic [22:0] a_frac, b_frac;
    logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, sign;

    assign a_exp  = a_q[30:23];
    assign b_exp  = b_q[30:23];
    assign a_frac = a_q[22:0];
    assign b_frac = b_q[22:0];
    assign a_nan  = (&a_exp) && (|a_frac);
    assign b_nan  = (&b_exp) && (|b_frac);
    assign a_snan = a_nan && !a_frac[22];
    assign b_snan = b_nan && !b_frac[22];
    assign a_inf  = (&a_exp) && !(|a_frac);
    assign b_inf  = (&b_exp) && !(|b_frac);
    assign a_zero = (a_q[30:0] == 31'd0);
    assign b_zero = (b_q[30:0] == 31'd0);
    assign sign   = a_q[31] ^ b_q[31];

    // One normalisation step; on the final step also align sigA >= sigB.
    logic [24:0]       na;
    logic [23:0]       nb;
    logic signed [9:0] ea, eb;
    logic              norm_done;
    always_comb begin
        na = sig_a_q[23] ? sig_a_q : {sig_a_q[23:0], 1'b0};
        ea = sig_a_q[23] ? exp_a_q : exp_a_q - 10'sd1;
        nb = sig_b_q[23] ? sig_b_q : {sig_b_q[22:0], 1'b0};
        eb = sig_b_q[23] ? exp_b_q : exp_b_q - 10'sd1;
        norm_done = na[23] && nb[23];
        if (norm_done && (na < {1'b0, nb})) begin
            na = {na[23:0], 1'b0};
            ea = ea - 10'sd1;
        end
    end

    logic [25:0] diff;
    logic        qbit;
    logic [24:0] rem;
    always_comb begin
        diff = {1'b0, sig_a_q} - {2'b00, sig_b_q};
        qbit = !diff[25];
        rem  = qbit ? diff[24:0] : sig_a_q;
    end

    logic        e_le0, lsb, g, r, st, inc, ovf, inf_sel;
    logic [9:0]  sh_raw, ebase;
    logic [4:0]  sh;
    logic [51:0] wide;
    logic [25:0] q_s;
    logic [32:0] sum;
    logic [31:0] rnd_res;
    logic [4:0]  rnd_flg;
    always_comb begin
        e_le0  = (exp_a_q <= 10'sd0);
        sh_raw = 10'd1 - exp_a_q;
        sh     = 5'd0;
        if (e_le0)
            sh = (sh_raw > 10'd26) ? 5'd26 : sh_raw[4:0];
        wide  = {quo_q, 26'd0} >> sh;
        q_s   = wide[51:26];
        st    = (|sig_a_q) || (|wide[25:0]);
        lsb   = q_s[2];
        g     = q_s[1];
        r     = q_s[0];
        ebase = e_le0 ? 10'd0 : exp_a_q;
        unique case (frm_q)
            3'd0:    inc = g && (r || st || lsb);
            3'd2:    inc = sign && (g || r || st);
            3'd3:    inc = !sign && (g || r || st);
            3'd4:    inc = g;
            default: inc = 1'b0;
        endcase
        sum     = {ebase, q_s[24:2]} + {32'd0, inc};
        ovf     = (sum[32:23] >= 10'd255);
        inf_sel = (frm_q == 3'd0) || (frm_q == 3'd4)
               || (frm_q == 3'd3 && !sign) || (frm_q == 3'd2 && sign);
        rnd_res = {sign, sum[30:0]};
        if (ovf)
            rnd_res = inf_sel ? {sign, 8'hff, 23'd0} : {sign, 31'h7f7fffff};
        rnd_flg = {2'b00, ovf,
                   (sum[32:23] == 10'd0) && (g || r || st),
                   g || r || st || ovf};
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        frm_d      = frm_q;
        sig_a_d    = sig_a_q;
        sig_b_d    = sig_b_q;
        exp_a_d    = exp_a_q;
        exp_b_d    = exp_b_q;
        quo_d      = quo_q;
        cnt_d      = cnt_q;
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        spec_flg_d = spec_flg_q;
        c_d        = c_q;
        fflags_d   = fflags_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_i) begin
                    a_d     = rs1_i;
                    b_d     = rs2_i;
                    frm_d   = frm_i;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                spec_d     = 1'b1;
                spec_flg_d = 5'd0;
                spec_res_d = CANON_NAN;
                if (frm_q > 3'd4) begin
                    spec_flg_d = 5'b10000;
                end else if (a_nan || b_nan) begin
                    spec_flg_d = {a_snan || b_snan, 4'd0};
                end else if ((a_inf && b_inf) || (a_zero && b_zero)) begin
                    spec_flg_d = 5'b10000;
                end else if (a_inf) begin
                    spec_res_d = {sign, 8'hff, 23'd0};
                end else if (b_zero) begin
                    spec_res_d = {sign, 8'hff, 23'd0};
                    spec_flg_d = 5'b01000;
                end else if (a_zero || b_inf) begin
                    spec_res_d = {sign, 31'd0};
                end else begin
                    spec_d  = 1'b0;
                    sig_a_d = {1'b0, |a_exp, a_frac};
                    sig_b_d = {|b_exp, b_frac};
                    exp_a_d = (a_exp == 8'd0) ? 10'sd1 : $signed({2'b00, a_exp});
                    exp_b_d = (b_exp == 8'd0) ? 10'sd1 : $signed({2'b00, b_exp});
                end
                state_d = spec_d ? S_ROUND : S_NORM;
            end
            S_NORM: begin
                sig_a_d = na;
                sig_b_d = nb;
                exp_a_d = ea;
                exp_b_d = eb;
                if (norm_done) begin
                    exp_a_d = ea - eb + 10'sd127;
                    quo_d   = 26'd0;
                    cnt_d   = 5'd0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                sig_a_d = {rem[23:0], 1'b0};
                quo_d   = {quo_q[24:0], qbit};
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'(QBITS - 1))
                    state_d = S_ROUND;
            end
            S_ROUND: begin
                c_d      = spec_q ? spec_res_q : rnd_res;
                fflags_d = spec_q ? spec_flg_q : rnd_flg;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            frm_q      <= '0;
            sig_a_q    <= '0;
            sig_b_q    <= '0;
            exp_a_q    <= '0;
            exp_b_q    <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            spec_res_q <= '0;
            spec_flg_q <= '0;
            c_q        <= '0;
            fflags_q   <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            frm_q      <= frm_d;
            sig_a_q    <= sig_a_d;
            sig_b_q    <= sig_b_d;
            exp_a_q    <= exp_a_d;
            exp_b_q    <= exp_b_d;
            quo_q      <= quo_d;
            cnt_q      <= cnt_d;
            spec_q     <= spec_d;
            spec_res_q <= spec_res_d;
            spec_flg_q <= spec_flg_d;
            c_q        <= c_d;
            fflags_q   <= fflags_d;
        end
    end

    assign c_o      = c_q;
    assign fflags_o = fflags_q;
    assign done_o   = (state_q == S_DONE);
    assign busy_o   = (state_q != S_IDLE) && (state_q != S_DONE);
endmodule

// File: tb/tb_fdiv_fps_seq.sv
// Directed bench for fdiv_fps_seq: results, flags, latency, handshake, reset.
module tb_fdiv_fps_seq;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic [2:0]  frm_i = '0;
    logic [31:0] c_o;
    logic [4:0]  fflags_o;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;
    logic busy_bad;

    fdiv_fps_seq dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .frm_i    (frm_i),
        .c_o      (c_o),
        .fflags_o (fflags_o),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f);
        @(negedge clk_i);
        rs1_i   = a;
        rs2_i   = b;
        frm_i   = f;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        busy_bad = 1'b0;
        do begin
            @(posedge clk_i);
            #1;
            n++;
            if (!done_o && !busy_o)
                busy_bad = 1'b1;
        end while (!done_o && n < 200);
    endtask

    task automatic run(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic [2:0] f,
                       input logic [31:0] ec, input logic [4:0] ef,
                       input int lat, input bit b2b);
        int n;
        if (!b2b)
            repeat (2) @(posedge clk_i);
        launch(a, b, f);
        wait_done(n);
        check({tag, "_c"}, c_o, ec);
        check({tag, "_flags"}, {27'd0, fflags_o}, {27'd0, ef});
        if (lat > 0)
            check({tag, "_lat"}, n, lat);
    endtask

    initial begin
        int n;
        int seen;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_c", c_o, 32'h0);
        check("rst_flags", {27'd0, fflags_o}, 32'h0);
        check("rst_busy", {31'd0, busy_o}, 32'h0);
        check("rst_done", {31'd0, done_o}, 32'h0);
        rst_i = 1'b0;

        run("exact", 32'h3f800000, 32'h40000000, 3'd0,
            32'h3f000000, 5'b00000, 29, 1'b0);
        check("exact_busy_hold", {31'd0, busy_bad}, 32'h0);
        check("exact_busy_at_done", {31'd0, busy_o}, 32'h0);

        run("third_rne", 32'h3f800000, 32'h40400000, 3'd0,
            32'h3eaaaaab, 5'b00001, 29, 1'b0);
        run("third_rtz", 32'h3f800000, 32'h40400000, 3'd1,
            32'h3eaaaaaa, 5'b00001, 0, 1'b0);
        run("third_rdn", 32'h3f800000, 32'h40400000, 3'd2,
            32'h3eaaaaaa, 5'b00001, 0, 1'b0);
        run("third_rup", 32'h3f800000, 32'h40400000, 3'd3,
            32'h3eaaaaab, 5'b00001, 0, 1'b0);
        run("third_rmm", 32'h3f800000, 32'h40400000, 3'd4,
            32'h3eaaaaab, 5'b00001, 0, 1'b0);
        run("neg_third_rdn", 32'hbf800000, 32'h40400000, 3'd2,
            32'hbeaaaaab, 5'b00001, 0, 1'b0);

        run("div_zero", 32'h3f800000, 32'h00000000, 3'd0,
            32'h7f800000, 5'b01000, 2, 1'b0);
        run("zero_zero", 32'h00000000, 32'h00000000, 3'd0,
            32'h7fc00000, 5'b10000, 2, 1'b0);
        run("snan", 32'h7f800001, 32'h3f800000, 3'd0,
            32'h7fc00000, 5'b10000, 2, 1'b0);
        run("qnan", 32'h7fc00000, 32'h3f800000, 3'd0,
            32'h7fc00000, 5'b00000, 2, 1'b0);
        run("bad_frm", 32'h3f800000, 32'h40000000, 3'd5,
            32'h7fc00000, 5'b10000, 2, 1'b0);

        run("ovf_rne", 32'h7f7fffff, 32'h3f000000, 3'd0,
            32'h7f800000, 5'b00101, 29, 1'b0);
        run("ovf_rtz", 32'h7f7fffff, 32'h3f000000, 3'd1,
            32'h7f7fffff, 5'b00101, 0, 1'b0);
        run("ovf_neg_rup", 32'hff7fffff, 32'h3f000000, 3'd3,
            32'hff7fffff, 5'b00101, 0, 1'b0);

        run("sub_min", 32'h00000001, 32'h3f000000, 3'd0,
            32'h00000002, 5'b00000, 51, 1'b0);
        run("sub_half", 32'h00800000, 32'h40000000, 3'd0,
            32'h00400000, 5'b00000, 29, 1'b0);
        run("sub_tie", 32'h00800001, 32'h40000000, 3'd0,
            32'h00400000, 5'b00011, 29, 1'b0);

        // A second start while busy must be ignored.
        repeat (2) @(posedge clk_i);
        launch(32'h3f800000, 32'h40400000, 3'd0);
        repeat (10) @(posedge clk_i);
        @(negedge clk_i);
        rs1_i   = 32'h40000000;
        rs2_i   = 32'h3f800000;
        frm_i   = 3'd1;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        wait_done(n);
        check("ignore_c", c_o, 32'h3eaaaaab);
        check("ignore_flags", {27'd0, fflags_o}, 32'h1);
        check("ignore_lat", 11 + n, 29);

        // Start during the done cycle is accepted.
        run("b2b", 32'h3f800000, 32'h40000000, 3'd0,
            32'h3f000000, 5'b00000, 29, 1'b1);

        // Reset in the middle of DIV aborts without a late done.
        repeat (2) @(posedge clk_i);
        launch(32'h3f800000, 32'h40400000, 3'd0);
        repeat (15) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("midrst_busy", {31'd0, busy_o}, 32'h0);
        check("midrst_c", c_o, 32'h0);
        check("midrst_flags", {27'd0, fflags_o}, 32'h0);
        check("midrst_done", {31'd0, done_o}, 32'h0);
        seen = 0;
        repeat (40) begin
            @(posedge clk_i);
            #1;
            if (done_o || busy_o)
                seen++;
        end
        check("midrst_no_late_done", seen, 0);

        run("after_rst", 32'h3f800000, 32'h40000000, 3'd0,
            32'h3f000000, 5'b00000, 29, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
